// File: rtl/win_pkg.sv
// Shared constants and FSM state type for the framer and the window stage.
package win_pkg;

  localparam int unsigned DWIDTH = 16;
  localparam int unsigned NWIN   = 32;
  localparam int unsigned IWIDTH = 5;

  typedef enum logic {
    IDLE,
    READ
  } state_e;

endpackage

// File: rtl/win_framer_if.sv
// Sample stream in (dv_in/din_*/din_ready), indexed frame stream out
// (dv_out/index_out/dout_*), plus the sticky drop_err flag.
interface win_framer_if #(
  parameter int unsigned Dwidth = 16,
  parameter int unsigned Iwidth = 5
) ();

  logic              dv_in;
  logic [Dwidth-1:0] din_imag;
  logic [Dwidth-1:0] din_real;
  logic              din_ready;
  logic              dv_out;
  logic [Iwidth-1:0] index_out;
  logic [Dwidth-1:0] dout_imag;
  logic [Dwidth-1:0] dout_real;
  logic              drop_err;

  modport slave (
    input  dv_in, din_imag, din_real,
    output din_ready, dv_out, index_out, dout_imag, dout_real, drop_err
  );

  modport master (
    output dv_in, din_imag, din_real,
    input  din_ready, dv_out, index_out, dout_imag, dout_real, drop_err
  );

endinterface

// File: rtl/frame_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module frame_ram #(
  parameter int unsigned Awidth = 6,
  parameter int unsigned Width  = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [Awidth-1:0] waddr,
  input  logic [Width-1:0]  wdata,
  input  logic              re,
  input  logic [Awidth-1:0] raddr,
  output logic [Width-1:0]  rdata
);

  logic [Width-1:0] mem_q [2**Awidth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/win_framer.sv
// Overlapping frame generator: buffers samples in a 2*Nwin circular RAM and
// emits Nwin-sample frames at hop Nwin/2, each sample tagged with its index.
// Ports: clk, async reset, sync flush, bus (win_framer_if.slave).
module win_framer
  import win_pkg::*;
#(
  parameter int unsigned Dwidth = DWIDTH,
  parameter int unsigned Nwin   = NWIN,
  parameter int unsigned Iwidth = IWIDTH
) (
  input logic         clk,
  input logic         reset,
  input logic         flush,
  win_framer_if.slave bus
);

  localparam int unsigned PW = Iwidth + 1;
  localparam int unsigned OW = Iwidth + 2;
  localparam logic [OW-1:0]     OCC_FULL  = OW'(2 * Nwin);
  localparam logic [OW-1:0]     OCC_FRAME = OW'(Nwin);
  localparam logic [OW-1:0]     OCC_HOP   = OW'(Nwin / 2);
  localparam logic [PW-1:0]     PTR_HOP   = PW'(Nwin / 2);
  localparam logic [Iwidth-1:0] IDX_LAST  = Iwidth'(Nwin - 1);

  state_e            state_q, state_d;
  logic [PW-1:0]     wp_q, wp_d;
  logic [PW-1:0]     fs_q, fs_d;
  // Kept as its own register: wp - fs alone cannot tell empty from full.
  logic [OW-1:0]     occ_q, occ_d;
  logic [Iwidth-1:0] rd_idx_q, rd_idx_d;
  logic              drop_q, drop_d;
  logic              v1_q, v1_d;
  logic [Iwidth-1:0] idx1_q, idx1_d;
  logic              dv_out_q, dv_out_d;
  logic [Iwidth-1:0] index_q, index_d;
  logic [Dwidth-1:0] dout_real_q, dout_real_d;
  logic [Dwidth-1:0] dout_imag_q, dout_imag_d;

  logic              din_ready;
  logic              wr_en;
  logic              rd_en;
  logic              adv;
  logic [PW-1:0]     rd_addr;
  logic [2*Dwidth-1:0] ram_rdata;

  frame_ram #(
    .Awidth(PW),
    .Width (2 * Dwidth)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wp_q),
    .wdata({bus.din_imag, bus.din_real}),
    .re   (rd_en),
    .raddr(rd_addr),
    .rdata(ram_rdata)
  );

  always_comb begin
    din_ready = (occ_q < OCC_FULL);
    wr_en     = bus.dv_in && din_ready && !flush;
    rd_en     = 1'b0;
    adv       = 1'b0;
    rd_addr   = fs_q + PW'(rd_idx_q);
    state_d   = state_q;
    rd_idx_d  = rd_idx_q;

    case (state_q)
      IDLE: begin
        if (occ_q >= OCC_FRAME) begin
          state_d  = READ;
          rd_idx_d = '0;
        end
      end
      READ: begin
        rd_en    = 1'b1;
        rd_idx_d = rd_idx_q + 1'b1;
        if (rd_idx_q == IDX_LAST) begin
          adv      = 1'b1;
          rd_idx_d = '0;
          state_d  = ((occ_q - OCC_HOP) >= OCC_FRAME) ? READ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wp_d   = wr_en ? wp_q + 1'b1 : wp_q;
    fs_d   = adv ? fs_q + PTR_HOP : fs_q;
    occ_d  = occ_q + OW'(wr_en) - (adv ? OCC_HOP : '0);
    drop_d = drop_q | (bus.dv_in & ~din_ready);

    v1_d        = rd_en;
    idx1_d      = rd_idx_q;
    dv_out_d    = v1_q;
    index_d     = v1_q ? idx1_q : index_q;
    dout_real_d = v1_q ? ram_rdata[Dwidth-1:0] : dout_real_q;
    dout_imag_d = v1_q ? ram_rdata[2*Dwidth-1:Dwidth] : dout_imag_q;

    if (flush) begin
      wp_d     = '0;
      fs_d     = '0;
      occ_d    = '0;
      rd_idx_d = '0;
      state_d  = IDLE;
      v1_d     = 1'b0;
      dv_out_d = 1'b0;
      drop_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wp_q        <= '0;
      fs_q        <= '0;
      occ_q       <= '0;
      rd_idx_q    <= '0;
      drop_q      <= 1'b0;
      v1_q        <= 1'b0;
      idx1_q      <= '0;
      dv_out_q    <= 1'b0;
      index_q     <= '0;
      dout_real_q <= '0;
      dout_imag_q <= '0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      fs_q        <= fs_d;
      occ_q       <= occ_d;
      rd_idx_q    <= rd_idx_d;
      drop_q      <= drop_d;
      v1_q        <= v1_d;
      idx1_q      <= idx1_d;
      dv_out_q    <= dv_out_d;
      index_q     <= index_d;
      dout_real_q <= dout_real_d;
      dout_imag_q <= dout_imag_d;
    end
  end

  assign bus.din_ready = din_ready;
  assign bus.dv_out    = dv_out_q;
  assign bus.index_out = index_q;
  assign bus.dout_real = dout_real_q;
  assign bus.dout_imag = dout_imag_q;
  assign bus.drop_err  = drop_q;

endmodule

// File: tb/tb_win_framer.sv
module tb_win_framer;

  localparam int DW = 16;
  localparam int N  = 32;
  localparam int IW = 5;
  localparam int H  = N / 2;

  logic clk;
  logic reset;
  logic flush;

  win_framer_if #(.Dwidth(DW), .Iwidth(IW)) bus ();

  win_framer #(
    .Dwidth(DW),
    .Nwin  (N),
    .Iwidth(IW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: every accepted sample in order; frame k index i is
  // accepted sample k*H + i.
  logic [2*DW-1:0] acc[$];
  int   out_cnt       = 0;
  int   first_out_cyc = -1;
  int   last_out_cyc  = -1;
  int   cap_cyc       = -1;
  logic drop_exp      = 1'b0;
  int   pos;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    acc.delete();
    out_cnt       = 0;
    first_out_cyc = -1;
    last_out_cyc  = -1;
    cap_cyc       = -1;
    drop_exp      = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      model_clear();
    end else begin
      if (out_cnt % N != 0) chk("frame_gap", 64'(bus.dv_out), 64'(1));
      if (bus.dv_out === 1'b1) begin
        pos = (out_cnt / N) * H + (out_cnt % N);
        chk("index", 64'(bus.index_out), 64'(out_cnt % N));
        chk("out_has_source", 64'(pos < int'(acc.size())), 64'(1));
        if (pos < int'(acc.size()))
          chk("data", 64'({bus.dout_imag, bus.dout_real}), 64'(acc[pos]));
        if (out_cnt == 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        out_cnt++;
      end
      chk("drop_err", 64'(bus.drop_err), 64'(drop_exp));
      if (flush) begin
        model_clear();
      end else begin
        if (bus.dv_in && bus.din_ready) begin
          acc.push_back({bus.din_imag, bus.din_real});
          if (acc.size() == N) cap_cyc = cyc + 1;
        end
        if (bus.dv_in && !bus.din_ready) drop_exp = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    bus.dv_in = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic drain(input int n);
    bus.dv_in = 1'b0;
    repeat (n) step();
  endtask

  task automatic feed_full(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      bus.dv_in    = 1'b1;
      bus.din_real = 16'(base + k);
      bus.din_imag = 16'($urandom);
      step();
    end
    bus.dv_in = 1'b0;
  endtask

  function automatic int exp_outputs();
    int a;
    a = int'(acc.size());
    return (a >= N) ? ((a - N) / H + 1) * N : 0;
  endfunction

  int first_low;
  int hit;

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bus.dv_in    = 1'b0;
    bus.din_real = '0;
    bus.din_imag = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_din_ready", 64'(bus.din_ready), 64'(1));
    chk("rst_dv_out", 64'(bus.dv_out), 64'(0));
    chk("rst_index", 64'(bus.index_out), 64'(0));
    chk("rst_dout", 64'({bus.dout_imag, bus.dout_real}), 64'(0));
    chk("rst_drop_err", 64'(bus.drop_err), 64'(0));
    reset = 1'b0;
    step();

    // Ramp at half rate: 96 samples -> 5 frames.
    for (int n = 0; n < 96; n++) begin
      bus.dv_in    = 1'b1;
      bus.din_real = 16'(n);
      bus.din_imag = 16'(-n);
      step();
      bus.dv_in = 1'b0;
      step();
    end
    drain(150);
    chk("ramp_outputs", 64'(out_cnt), 64'(5 * N));
    chk("ramp_latency", 64'(first_out_cyc - cap_cyc), 64'(3));

    // Full-rate latency and contiguity.
    do_flush();
    feed_full(N, 500);
    drain(100);
    chk("lat_latency", 64'(first_out_cyc - cap_cyc), 64'(3));
    chk("lat_outputs", 64'(out_cnt), 64'(N));
    chk("lat_contig", 64'(last_out_cyc - first_out_cyc + 1), 64'(N));

    // Backpressure with a source that honours din_ready.
    do_flush();
    first_low = -1;
    for (int c = 0; c < 200; c++) begin
      if (!bus.din_ready && first_low < 0) first_low = int'(acc.size());
      bus.dv_in    = bus.din_ready;
      bus.din_real = 16'($urandom);
      bus.din_imag = 16'($urandom);
      step();
    end
    drain(150);
    chk("bp_first_full", 64'(first_low), 64'(2 * N));
    chk("bp_outputs", 64'(out_cnt), 64'(exp_outputs()));
    chk("bp_contig", 64'(last_out_cyc - first_out_cyc + 1), 64'(out_cnt));

    // Random-rate source honouring din_ready.
    do_flush();
    for (int c = 0; c < 300; c++) begin
      bus.dv_in    = ($urandom_range(0, 2) != 0) && bus.din_ready;
      bus.din_real = 16'($urandom);
      bus.din_imag = 16'($urandom);
      step();
    end
    drain(150);
    chk("rand_outputs", 64'(out_cnt), 64'(exp_outputs()));

    // Drops: offer every cycle regardless of din_ready.
    do_flush();
    for (int c = 0; c < 100; c++) begin
      bus.dv_in    = 1'b1;
      bus.din_real = 16'($urandom);
      bus.din_imag = 16'($urandom);
      step();
    end
    drain(150);
    chk("drop_sticky", 64'(bus.drop_err), 64'(1));
    chk("drop_outputs", 64'(out_cnt), 64'(exp_outputs()));
    do_flush();
    chk("drop_cleared", 64'(bus.drop_err), 64'(0));
    chk("flush_ready", 64'(bus.din_ready), 64'(1));

    // Reset in the middle of a frame.
    feed_full(40, 2000);
    hit = 0;
    for (int k = 0; k < 200 && hit == 0; k++) begin
      @(negedge clk);
      #1;
      if (bus.dv_out === 1'b1 && bus.index_out === 5'd10) hit = 1;
    end
    chk("rst_wait_idx10", 64'(hit), 64'(1));
    reset     = 1'b1;
    bus.dv_in = 1'b0;
    #1;
    chk("mrst_dv_out", 64'(bus.dv_out), 64'(0));
    chk("mrst_index", 64'(bus.index_out), 64'(0));
    chk("mrst_dout", 64'({bus.dout_imag, bus.dout_real}), 64'(0));
    chk("mrst_ready", 64'(bus.din_ready), 64'(1));
    chk("mrst_drop", 64'(bus.drop_err), 64'(0));
    step();
    step();
    reset = 1'b0;
    feed_full(N, 1000);
    drain(100);
    chk("mrst_outputs", 64'(out_cnt), 64'(N));
    chk("mrst_latency", 64'(first_out_cyc - cap_cyc), 64'(3));

    // Flush in the middle of a frame.
    do_flush();
    feed_full(40, 3000);
    hit = 0;
    for (int k = 0; k < 200 && hit == 0; k++) begin
      step();
      if (bus.dv_out === 1'b1 && bus.index_out === 5'd20) hit = 1;
    end
    chk("flush_wait_idx20", 64'(hit), 64'(1));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_dv_out0", 64'(bus.dv_out), 64'(0));
    step();
    chk("flush_dv_out1", 64'(bus.dv_out), 64'(0));
    feed_full(N, 4000);
    drain(100);
    chk("flush_outputs", 64'(out_cnt), 64'(N));
    chk("flush_latency", 64'(first_out_cyc - cap_cyc), 64'(3));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
